// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH(31,16) encoder/checker pair.
// g(x) = x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1, top term implicit.
package bch_pkg;

  localparam int N   = 31;
  localparam int K   = 16;
  localparam int N_K = 15;

  localparam logic [14:0] G_POLY = 15'h0FAF;

  typedef logic [30:0] codeword_t;
  typedef logic [15:0] data_t;
  typedef logic [14:0] syndrome_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bch_lfsr_div.sv
// Serial GF(2) divider by g(x), one bit per clock, MSB first.
// Register holds the running remainder of the bits fed so far.
module bch_lfsr_div
  import bch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clr,
  input  logic      en,
  input  logic      bit_in,
  output syndrome_t rem
);

  // Shift the new bit in; reduce by g(x) when x^15 pops out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem <= '0;
    end else if (clr) begin
      rem <= '0;
    end else if (en) begin
      rem <= {rem[13:0], bit_in}
           ^ (rem[14] ? G_POLY : '0);
    end
  end

endmodule

// File: rtl/bch_syndrome_checker.sv
// BCH(31,16) syndrome checker: serial remainder of the received
// word mod g(x), reports data, syndrome and error flag.
module bch_syndrome_checker
  import bch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  codeword_t indata,
  input  logic      inready,
  output data_t     dataout,
  output syndrome_t syndrome,
  output logic      err,
  output logic      outready,
  output logic      busy,
  output logic      overrun
);

  state_t    state;
  codeword_t sr;
  logic [4:0] count;
  data_t     data_q;
  syndrome_t rem;
  logic      div_clr;
  logic      div_en;

  assign div_clr = (state == IDLE) && inready;
  assign div_en  = (state == SHIFT);

  bch_lfsr_div u_div (
    .clk    (clk),
    .reset  (reset),
    .clr    (div_clr),
    .en     (div_en),
    .bit_in (sr[30]),
    .rem    (rem)
  );

  // Load, shift 31 bits, publish result for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sr       <= '0;
      count    <= '0;
      data_q   <= '0;
      dataout  <= '0;
      syndrome <= '0;
      err      <= 1'b0;
      outready <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      outready <= 1'b0;
      if (inready && busy)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (inready) begin
            sr     <= indata;
            data_q <= indata[30:15];
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr <= sr << 1;
          if (count == 5'd30)
            state <= DONE;
          else
            count <= count + 5'd1;
        end
        DONE: begin
          syndrome <= rem;
          err      <= |rem;
          dataout  <= data_q;
          outready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_checker.sv
// Directed bench for bch_syndrome_checker with a
// long-division reference model and per-cycle compare.
module tb_bch_syndrome_checker;

  logic        clk;
  logic        reset;
  logic [30:0] indata;
  logic        inready;
  logic [15:0] dataout;
  logic [14:0] syndrome;
  logic        err;
  logic        outready;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  bch_syndrome_checker dut (
    .clk      (clk),
    .reset    (reset),
    .indata   (indata),
    .inready  (inready),
    .dataout  (dataout),
    .syndrome (syndrome),
    .err      (err),
    .outready (outready),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mod_g(input logic [30:0] w);
    logic [30:0] t;
    logic [30:0] g;
    t = w;
    for (int i = 30; i >= 15; i--) begin
      if (t[i]) begin
        g = 31'h0000_8FAF;
        t = t ^ (g << (i - 15));
      end
    end
    return t[14:0];
  endfunction

  function automatic logic [30:0] encode(input logic [15:0] d);
    logic [30:0] w;
    w = {d, 15'h0};
    return w | {16'h0, mod_g(w)};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h",
               name, act, exp);
    end
  endtask

  // Reference model: accepted words and their due cycle.
  int          cyc;
  int          free_at;
  int          done_at;
  logic [15:0] p_data;
  logic [14:0] p_syn;
  logic [15:0] m_data;
  logic [14:0] m_syn;
  logic        m_err;
  logic        m_out;
  logic        m_busy;
  logic        m_ovr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; free_at = 0; done_at = -1;
      p_data = '0; p_syn = '0;
      m_data = '0; m_syn = '0; m_err = 1'b0;
      m_out = 1'b0; m_busy = 1'b0; m_ovr = 1'b0;
    end else begin
      cyc++;
      m_out = 1'b0;
      if (cyc == done_at) begin
        m_out  = 1'b1;
        m_busy = 1'b0;
        m_data = p_data;
        m_syn  = p_syn;
        m_err  = (p_syn != 0);
      end
      if (inready) begin
        if (cyc >= free_at) begin
          done_at = cyc + 32;
          free_at = cyc + 33;
          p_data  = indata[30:15];
          p_syn   = mod_g(indata);
          m_busy  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("outready", outready, m_out);
    chk("busy", busy, m_busy);
    chk("overrun", overrun, m_ovr);
    chk("dataout", dataout, m_data);
    chk("syndrome", syndrome, m_syn);
    chk("err", err, m_err);
  end

  task automatic send(input logic [30:0] w);
    indata  = w;
    inready = 1'b1;
    @(negedge clk);
    inready = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (outready) break;
    end
    if (!outready) chk("timeout", 0, 1);
  endtask

  task automatic count_pulses(input int len, output int p);
    p = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (outready) p++;
    end
  endtask

  task automatic chk_res(input string tag,
                         input logic [15:0] d,
                         input logic [14:0] s,
                         input logic e);
    chk({tag, "_data"}, dataout, d);
    chk({tag, "_syn"}, syndrome, s);
    chk({tag, "_err"}, err, e);
  endtask

  int n;
  int p;

  initial begin
    reset   = 1'b0;
    inready = 1'b0;
    indata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_outready", outready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk_res("rst", 16'h0, 15'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    chk("model_g", mod_g(31'h0000_8FAF), 15'h0);
    chk("model_x15", mod_g(31'h0000_8000), 15'h0FAF);
    chk("model_x0", mod_g(31'h1), 15'h1);

    send(31'h0);
    wait_out(n);
    chk("lat_zero", n, 32);
    chk_res("zero", 16'h0, 15'h0, 1'b0);

    send(31'h0000_8FAF);
    wait_out(n);
    chk("lat_g", n, 32);
    chk_res("g", 16'h1, 15'h0, 1'b0);

    send(encode(16'd65));
    wait_out(n);
    chk("lat_b2b", n, 32);
    chk_res("d65", 16'd65, 15'h0, 1'b0);

    repeat (2) @(negedge clk);
    send(encode(16'd65) ^ 31'h1);
    wait_out(n);
    chk_res("d65_flip", 16'd65, 15'h1, 1'b1);

    send(31'h0000_8000);
    wait_out(n);
    chk_res("x15", 16'h1, 15'h0FAF, 1'b1);

    send(encode(16'hBEEF));
    repeat (15) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("ar_outready", outready, 0);
    chk("ar_busy", busy, 0);
    chk("ar_overrun", overrun, 0);
    chk_res("ar", 16'h0, 15'h0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_pulses(40, p);
    chk("ar_no_pulse", p, 0);
    send(31'h0000_8FAF);
    wait_out(n);
    chk("lat_after_rst", n, 32);
    chk_res("after_rst", 16'h1, 15'h0, 1'b0);

    send(encode(16'h1234));
    repeat (9) @(negedge clk);
    send(31'h0000_8000);
    chk("ovr_set", overrun, 1);
    wait_out(n);
    chk_res("ovr", 16'h1234, 15'h0, 1'b0);
    count_pulses(40, p);
    chk("ovr_one_pulse", p, 0);
    chk("ovr_sticky", overrun, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
